pu_ex_muldiv: RTL and testbench
===============================

// Module: pu_ex_muldiv
// PURPOSE
//  Multi-cycle MULT/MULTU/DIV/DIVU unit in the EX stage; sole writer of the per-PID HI/LO register file.
//  Accepts one op at a time, tagged with a PID. Iterates, then pulses hi_wr_en/lo_wr_en with wr_pid.
//  Issue logic uses busy/busy_pid to stall MFHI/MFLO and further mul/div ops of that PID.
// PARAMETERS
//  none; widths come from `WORD_DATA_W (32), `PuPidBus, `PU_PID_NUM in pu.h/stddef.h
// PORTS
//  clk         in   1              clock; single clock domain
//  rst         in   1              synchronous, active-high reset
//  req_valid   in   1              op request
//  req_ready   out  1              unit can accept; = (state==IDLE)
//  req_op      in   `PuMdOpBus     MULT=0 MULTU=1 DIV=2 DIVU=3
//  req_pid     in   `PuPidBus      thread of the op
//  req_a       in   `WordDataBus   rs (multiplicand / dividend)
//  req_b       in   `WordDataBus   rt (multiplier / divisor)
//  kill        in   1              flush request
//  kill_pid    in   `PuPidBus      thread being flushed
//  busy        out  1              op in flight (state!=IDLE)
//  busy_pid    out  `PuPidBus      PID of the in-flight op
//  wr_pid      out  `PuPidBus      PID for the HI/LO write port
//  hi_wr_en    out  1              HI write strobe
//  hi_wr_data  out  `WordDataBus   HI value
//  lo_wr_en    out  1              LO write strobe
//  lo_wr_data  out  `WordDataBus   LO value
// BEHAVIOUR
//  - Reset: state=IDLE; busy, busy_pid, wr_pid, hi/lo_wr_en and hi/lo_wr_data all 0.
//  - Accept at cycle t when req_valid&&req_ready. Latch op, pid, |a|, |b| and signs (signed ops only).
//  - FSM: IDLE -> ITER (32 cycles, t+1..t+32) -> FIX (t+33) -> DONE (t+34) -> IDLE.
//  - DONE: hi_wr_en=lo_wr_en=1 for exactly one cycle, with wr_pid=busy_pid. Strobes are 0 in every other state.
//  - Write data is registered; it holds its last value while the strobes are low.
//  - MUL ITER: shift-add over the 64-bit {HI,LO} accumulator. FIX negates the 64-bit product if sign_a^sign_b.
//  - DIV ITER: restoring division, one quotient bit per cycle; LO=quotient, HI=remainder.
//    FIX: quotient negated if sign_a^sign_b; remainder takes the dividend's sign.
//  - Divide by zero (DIV/DIVU): LO=32'hFFFF_FFFF, HI=req_a.
//  - DIV 32'h8000_0000 / 32'hFFFF_FFFF: LO=32'h8000_0000, HI=0.
//  - Kill: kill&&kill_pid==busy_pid in any non-IDLE state -> IDLE next cycle, no write.
//    If that state is DONE, kill suppresses both strobes (kill wins).
//    kill&&kill_pid==req_pid in the accept cycle: request consumed and discarded, state stays IDLE.
//    A kill for another PID, or while IDLE, has no effect.
//  - No back-to-back accept: req_ready is low in DONE, so the next accept is at t+35 at the earliest.
//  - rst mid-operation aborts with no write; rst overrides kill and req_valid.
// CONFIGURATION
//  - PU_MULDIV_FAST_MUL_EN defined: MULT/MULTU bypass ITER.
//    One registered 32x32 multiply cycle (t+1), then FIX (t+2), then DONE (t+3).
//    DIV/DIVU timing is unchanged.
//  - Undefined: all ops use the 32-cycle ITER path (write at t+34).
// STRUCTURE
//  - pu.h: `PU_MD_OP_MULT/MULTU/DIV/DIVU, `PuMdOpBus, `PU_MD_OP_W, and FSM codes `PU_MD_ST_IDLE/ITER/FIX/DONE.
//  - Sub-module pu_ex_muldiv_step (combinational): one shift-add / restoring-subtract step,
//    selected by an is_div input. Instanced once; the FSM, counter, sign fix-up and kill logic stay in the top level.
// TESTING
//  1 MULT a=32'hFFFF_FFFE(-2) b=3 pid=1 -> one strobe at t+34 (t+3 fast), HI=FFFF_FFFF LO=FFFF_FFFA wr_pid=1
//  2 MULTU a=b=32'hFFFF_FFFF -> HI=FFFF_FFFE LO=0000_0001
//  3 DIV a=-7 b=2 -> LO=FFFF_FFFD(-3) HI=FFFF_FFFF(-1); DIVU a=7 b=0 -> LO=FFFF_FFFF HI=7
//  4 DIV 8000_0000 / FFFF_FFFF -> LO=8000_0000 HI=0; req_ready low t..t+34, busy_pid held throughout
//  5 DIVU pid=2; kill pid=2 at t+10 -> IDLE at t+11, no strobe; repeat with kill at DONE -> no strobe;
//    kill pid=3 -> normal write
//  6 rst at t+5 of MULT -> outputs 0, req_ready=1 next cycle; new DIVU accepted and completes correctly

Source files
------------

// File: rtl/pu_ex_muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pu_ex_muldiv_pkg
// Purpose : Shared widths, op codes and FSM state codes for the EX-stage
//           multiply/divide unit (pu_ex_muldiv) and its datapath step.
// Revision: 1.0 - initial release
// ============================================================================
package pu_ex_muldiv_pkg;

    localparam int WORD_DATA_W = 32;
    localparam int PU_PID_NUM  = 4;
    localparam int PU_PID_W    = 2;
    localparam int PU_MD_OP_W  = 2;

    typedef enum logic [PU_MD_OP_W-1:0] {
        PU_MD_OP_MULT  = 2'd0,
        PU_MD_OP_MULTU = 2'd1,
        PU_MD_OP_DIV   = 2'd2,
        PU_MD_OP_DIVU  = 2'd3
    } pu_md_op_e;

    typedef enum logic [1:0] {
        PU_MD_ST_IDLE = 2'd0,
        PU_MD_ST_ITER = 2'd1,
        PU_MD_ST_FIX  = 2'd2,
        PU_MD_ST_DONE = 2'd3
    } pu_md_st_e;

    // Magnitude of a word when it is to be treated as negative.
    function automatic logic [WORD_DATA_W-1:0] mag_word(input logic [WORD_DATA_W-1:0] v,
                                                        input logic                   neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pu_ex_muldiv_step.sv
`default_nettype none
// ============================================================================
// Module  : pu_ex_muldiv_step
// Purpose : One iteration of the 64-bit {HI,LO} accumulator datapath.
//           Multiply: shift-add (multiplier in acc[31:0], partial product
//           grows into acc[63:32] while the multiplier shifts out).
//           Divide  : restoring step (remainder in acc[63:32], dividend
//           shifting out of acc[31:0] while quotient bits shift in).
// Ports   : i_is_div - selects divide step; i_acc - accumulator in;
//           i_opnd   - multiplicand / divisor magnitude; o_acc - accumulator out
// Revision: 1.0 - initial release
// ============================================================================
module pu_ex_muldiv_step
    import pu_ex_muldiv_pkg::*;
(
    input  logic                     i_is_div,
    input  logic [2*WORD_DATA_W-1:0] i_acc,
    input  logic [WORD_DATA_W-1:0]   i_opnd,
    output logic [2*WORD_DATA_W-1:0] o_acc
);

    logic [WORD_DATA_W:0]   w_sum;      // partial product plus carry
    logic [WORD_DATA_W:0]   w_rem_sh;   // remainder shifted left with next dividend bit
    logic                   w_ge;
    logic [WORD_DATA_W-1:0] w_sub;

    always_comb begin
        w_sum    = {1'b0, i_acc[2*WORD_DATA_W-1:WORD_DATA_W]}
                 + (i_acc[0] ? {1'b0, i_opnd} : {(WORD_DATA_W+1){1'b0}});
        w_rem_sh = i_acc[2*WORD_DATA_W-1:WORD_DATA_W-1];
        w_ge     = (w_rem_sh >= {1'b0, i_opnd});
        // When w_ge holds the true difference is below the divisor, so the
        // low 32 bits of the modular subtraction are exact.
        w_sub    = w_rem_sh[WORD_DATA_W-1:0] - i_opnd;
        if (i_is_div) begin
            o_acc = w_ge ? {w_sub, i_acc[WORD_DATA_W-2:0], 1'b1}
                         : {w_rem_sh[WORD_DATA_W-1:0], i_acc[WORD_DATA_W-2:0], 1'b0};
        end else begin
            o_acc = {w_sum, i_acc[WORD_DATA_W-1:1]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/pu_ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module  : pu_ex_muldiv
// Purpose : Multi-cycle MULT/MULTU/DIV/DIVU unit; sole writer of the per-PID
//           HI/LO register file. One op in flight, tagged with a PID.
//           IDLE -> ITER (32 cycles) -> FIX (sign fix-up) -> DONE (write).
// Ports   : clk, rst (sync, active-high); req_valid/req_ready/req_op/req_pid/
//           req_a/req_b request; kill/kill_pid flush; busy/busy_pid status;
//           wr_pid, hi_wr_en/hi_wr_data, lo_wr_en/lo_wr_data write port.
// Config  : PU_MULDIV_FAST_MUL_EN - MULT/MULTU use one registered 32x32
//           multiply cycle instead of 32 shift-add cycles.
// Revision: 1.0 - initial release
// ============================================================================
module pu_ex_muldiv
    import pu_ex_muldiv_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [PU_MD_OP_W-1:0]  req_op,
    input  logic [PU_PID_W-1:0]    req_pid,
    input  logic [WORD_DATA_W-1:0] req_a,
    input  logic [WORD_DATA_W-1:0] req_b,
    input  logic                   kill,
    input  logic [PU_PID_W-1:0]    kill_pid,
    output logic                   busy,
    output logic [PU_PID_W-1:0]    busy_pid,
    output logic [PU_PID_W-1:0]    wr_pid,
    output logic                   hi_wr_en,
    output logic [WORD_DATA_W-1:0] hi_wr_data,
    output logic                   lo_wr_en,
    output logic [WORD_DATA_W-1:0] lo_wr_data
);

    pu_md_st_e                state_q,  state_d;
    logic [4:0]               cnt_q,    cnt_d;
    logic                     is_div_q, is_div_d;
    logic [PU_PID_W-1:0]      pid_q,    pid_d;
    logic [PU_PID_W-1:0]      wr_pid_q, wr_pid_d;
    logic                     sign_a_q, sign_a_d;
    logic                     sign_b_q, sign_b_d;
    logic [WORD_DATA_W-1:0]   opnd_q,   opnd_d;     // |a| for multiply, |b| for divide
    logic [2*WORD_DATA_W-1:0] acc_q,    acc_d;
    logic [WORD_DATA_W-1:0]   hi_q,     hi_d;
    logic [WORD_DATA_W-1:0]   lo_q,     lo_d;

    pu_md_op_e                w_op;
    logic                     w_req_signed;
    logic                     w_req_div;
    logic                     w_sa;
    logic                     w_sb;
    logic [WORD_DATA_W-1:0]   w_mag_a;
    logic [WORD_DATA_W-1:0]   w_mag_b;
    logic                     w_kill_hit;
    logic                     w_wr_en;
    logic                     w_neg_res;
    logic [2*WORD_DATA_W-1:0] w_prod;
    logic [2*WORD_DATA_W-1:0] w_step_acc;

    pu_ex_muldiv_step u_step (
        .i_is_div (is_div_q),
        .i_acc    (acc_q),
        .i_opnd   (opnd_q),
        .o_acc    (w_step_acc)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        pid_d    = pid_q;
        wr_pid_d = wr_pid_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        w_op         = pu_md_op_e'(req_op);
        w_req_signed = (w_op == PU_MD_OP_MULT) || (w_op == PU_MD_OP_DIV);
        w_req_div    = (w_op == PU_MD_OP_DIV)  || (w_op == PU_MD_OP_DIVU);
        w_sa         = w_req_signed & req_a[WORD_DATA_W-1];
        w_sb         = w_req_signed & req_b[WORD_DATA_W-1];
        w_mag_a      = mag_word(req_a, w_sa);
        w_mag_b      = mag_word(req_b, w_sb);
        w_kill_hit   = kill && (kill_pid == pid_q) && (state_q != PU_MD_ST_IDLE);
        w_neg_res    = sign_a_q ^ sign_b_q;
        w_prod       = w_neg_res ? (~acc_q + 1'b1) : acc_q;

        case (state_q)
            PU_MD_ST_IDLE: begin
                // A kill aimed at the requesting PID consumes the request.
                if (req_valid && !(kill && (kill_pid == req_pid))) begin
                    state_d  = PU_MD_ST_ITER;
                    cnt_d    = 5'd0;
                    is_div_d = w_req_div;
                    pid_d    = req_pid;
                    sign_a_d = w_sa;
                    sign_b_d = w_sb;
                    opnd_d   = w_req_div ? w_mag_b : w_mag_a;
                    acc_d    = {{WORD_DATA_W{1'b0}}, (w_req_div ? w_mag_a : w_mag_b)};
                end
            end
            PU_MD_ST_ITER: begin
`ifdef PU_MULDIV_FAST_MUL_EN
                if (!is_div_q) begin
                    acc_d   = {{WORD_DATA_W{1'b0}}, opnd_q} * {{WORD_DATA_W{1'b0}}, acc_q[WORD_DATA_W-1:0]};
                    state_d = PU_MD_ST_FIX;
                end else begin
                    acc_d = w_step_acc;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_d = PU_MD_ST_FIX;
                end
`else
                acc_d = w_step_acc;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = PU_MD_ST_FIX;
`endif
            end
            PU_MD_ST_FIX: begin
                wr_pid_d = pid_q;
                state_d  = PU_MD_ST_DONE;
                if (is_div_q) begin
                    // A zero divisor leaves remainder = |a|, so the dividend-sign
                    // fix below already yields HI = a; only LO needs forcing.
                    if (opnd_q == '0)   lo_d = '1;
                    else if (w_neg_res) lo_d = ~acc_q[WORD_DATA_W-1:0] + 1'b1;
                    else                lo_d = acc_q[WORD_DATA_W-1:0];
                    hi_d = mag_word(acc_q[2*WORD_DATA_W-1:WORD_DATA_W], sign_a_q);
                end else begin
                    hi_d = w_prod[2*WORD_DATA_W-1:WORD_DATA_W];
                    lo_d = w_prod[WORD_DATA_W-1:0];
                end
            end
            PU_MD_ST_DONE: begin
                state_d = PU_MD_ST_IDLE;
            end
            default: begin
                state_d = PU_MD_ST_IDLE;
            end
        endcase

        // A flushed op must leave the write port untouched.
        if (w_kill_hit) begin
            state_d  = PU_MD_ST_IDLE;
            wr_pid_d = wr_pid_q;
            hi_d     = hi_q;
            lo_d     = lo_q;
        end

        w_wr_en = (state_q == PU_MD_ST_DONE) && !w_kill_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= PU_MD_ST_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            pid_q    <= '0;
            wr_pid_q <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            pid_q    <= pid_d;
            wr_pid_q <= wr_pid_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign req_ready  = (state_q == PU_MD_ST_IDLE);
    assign busy       = (state_q != PU_MD_ST_IDLE);
    assign busy_pid   = pid_q;
    assign wr_pid     = wr_pid_q;
    assign hi_wr_en   = w_wr_en;
    assign lo_wr_en   = w_wr_en;
    assign hi_wr_data = hi_q;
    assign lo_wr_data = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_pu_ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module  : tb_pu_ex_muldiv
// Purpose : Self-checking bench for pu_ex_muldiv. Expected HI/LO writes are
//           queued at issue time and checked by a monitor on every strobe.
// Config  : honours PU_MULDIV_FAST_MUL_EN for multiply latency.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pu_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [1:0]  req_pid;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        kill;
    logic [1:0]  kill_pid;
    logic        busy;
    logic [1:0]  busy_pid;
    logic [1:0]  wr_pid;
    logic        hi_wr_en;
    logic [31:0] hi_wr_data;
    logic        lo_wr_en;
    logic [31:0] lo_wr_data;

    pu_ex_muldiv dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_pid    (req_pid),
        .req_a      (req_a),
        .req_b      (req_b),
        .kill       (kill),
        .kill_pid   (kill_pid),
        .busy       (busy),
        .busy_pid   (busy_pid),
        .wr_pid     (wr_pid),
        .hi_wr_en   (hi_wr_en),
        .hi_wr_data (hi_wr_data),
        .lo_wr_en   (lo_wr_en),
        .lo_wr_data (lo_wr_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  pid;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   total  = 0;
    int   passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: plain arithmetic on 64-bit values, MIPS semantics.
    function automatic logic [63:0] ref_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub, qv, rv;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        if (op >= 2'd2 && b == 32'd0) return {a, 32'hFFFF_FFFF};
        case (op)
            2'd0:    begin q = sa * sb; qv = q; return qv; end
            2'd1:    return ua * ub;
            2'd2:    begin q = sa / sb; r = sa % sb; qv = q; rv = r; return {rv[31:0], qv[31:0]}; end
            default: begin qv = ua / ub; rv = ua % ub; return {rv[31:0], qv[31:0]}; end
        endcase
    endfunction

    function automatic int latency(input logic [1:0] op);
`ifdef PU_MULDIV_FAST_MUL_EN
        if (op < 2'd2) return 2;
`endif
        return 33;
    endfunction

    // Monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && (hi_wr_en || lo_wr_en)) begin
            if (sb_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_strobe: got hi_en=%b lo_en=%b expected none (cycle %0d)",
                         hi_wr_en, lo_wr_en, cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("strobe_pair", {62'b0, hi_wr_en, lo_wr_en}, 64'd3);
                chk("wr_pid",      {62'b0, wr_pid}, {62'b0, e.pid});
                chk("hi_data",     {32'b0, hi_wr_data}, {32'b0, e.hi});
                chk("lo_data",     {32'b0, lo_wr_data}, {32'b0, e.lo});
                chk("latency",     64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [1:0] pid, input logic [31:0] a,
                         input logic [31:0] b, input bit kill_now, output int acc);
        int n = 0;
        while (!req_ready && n < 200) begin tick(); n++; end
        if (n >= 200) chk("ready_timeout", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_op = op; req_pid = pid; req_a = a; req_b = b;
        kill = kill_now; kill_pid = pid;
        tick();
        acc = cyc;
        req_valid = 1'b0; kill = 1'b0;
    endtask

    task automatic push(input logic [1:0] op, input logic [1:0] pid, input logic [63:0] hilo, input int acc);
        sb_q.push_back('{pid, hilo[63:32], hilo[31:0], acc + latency(op)});
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb_q.size() != 0 && n < 100) begin tick(); n++; end
        if (sb_q.size() != 0) begin
            chk("write_timeout", 64'(sb_q.size()), 64'd0);
            sb_q.delete();
        end
        tick();
    endtask

    task automatic run_op(input logic [1:0] op, input logic [1:0] pid, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] hilo);
        int acc;
        issue(op, pid, a, b, 1'b0, acc);
        push(op, pid, hilo, acc);
        wait_done();
    endtask

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int acc;
        rst = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_pid = 2'd0;
        req_a = 32'd0; req_b = 32'd0; kill = 1'b0; kill_pid = 2'd0;
        repeat (3) tick();
        chk("rst_busy",     64'(busy), 64'd0);
        chk("rst_ready",    64'(req_ready), 64'd1);
        chk("rst_busy_pid", 64'(busy_pid), 64'd0);
        chk("rst_wr_pid",   64'(wr_pid), 64'd0);
        chk("rst_wr_en",    {62'b0, hi_wr_en, lo_wr_en}, 64'd0);
        chk("rst_data",     {hi_wr_data, lo_wr_data}, 64'd0);
        rst = 1'b0;
        tick();

        // Directed results with literal expectations.
        run_op(2'd0, 2'd1, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA);
        repeat (3) tick();
        chk("data_hold_hi", 64'(hi_wr_data), 64'hFFFF_FFFF);
        chk("data_hold_lo", 64'(lo_wr_data), 64'hFFFF_FFFA);
        run_op(2'd1, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run_op(2'd2, 2'd3, 32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD);
        run_op(2'd3, 2'd2, 32'd7,         32'd0,         64'h0000_0007_FFFF_FFFF);
        run_op(2'd2, 2'd1, 32'hFFFF_FFF9, 32'd0,         64'hFFFF_FFF9_FFFF_FFFF);

        // Overflow divide, with ready/busy_pid held for the whole op.
        issue(2'd2, 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, acc);
        push(2'd2, 2'd2, 64'h0000_0000_8000_0000, acc);
        for (int k = 0; k < 34; k++) begin
            chk("ready_low", 64'(req_ready), 64'd0);
            chk("busy_pid",  64'(busy_pid), 64'd2);
            tick();
        end
        chk("ready_back", 64'(req_ready), 64'd1);
        wait_done();

        // Kill of the in-flight PID during ITER.
        issue(2'd3, 2'd2, 32'd1000, 32'd3, 1'b0, acc);
        while (cyc < acc + 9) tick();
        kill = 1'b1; kill_pid = 2'd2;
        tick();
        kill = 1'b0;
        chk("kill_iter_idle",  64'(busy), 64'd0);
        chk("kill_iter_ready", 64'(req_ready), 64'd1);
        repeat (40) tick();

        // Kill landing in DONE suppresses the write.
        issue(2'd3, 2'd2, 32'd1000, 32'd3, 1'b0, acc);
        while (cyc < acc + 33) tick();
        chk("kill_done_busy", 64'(busy), 64'd1);
        kill = 1'b1; kill_pid = 2'd2;
        tick();
        kill = 1'b0;
        chk("kill_done_idle", 64'(busy), 64'd0);
        repeat (5) tick();

        // Kill for another PID is ignored.
        issue(2'd3, 2'd2, 32'd1000, 32'd3, 1'b0, acc);
        push(2'd3, 2'd2, 64'h0000_0001_0000_014D, acc);
        while (cyc < acc + 9) tick();
        kill = 1'b1; kill_pid = 2'd3;
        tick();
        kill = 1'b0;
        wait_done();

        // Kill in the accept cycle discards the request.
        issue(2'd0, 2'd1, 32'd5, 32'd6, 1'b1, acc);
        chk("kill_accept_idle", 64'(busy), 64'd0);
        repeat (40) tick();

        // Reset mid-multiply aborts with no write.
        issue(2'd0, 2'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, acc);
`ifdef PU_MULDIV_FAST_MUL_EN
        push(2'd0, 2'd1, 64'hFFFF_FFFF_FFFF_FFFA, acc);
`endif
        while (cyc < acc + 4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy",   64'(busy), 64'd0);
        chk("mid_rst_ready",  64'(req_ready), 64'd1);
        chk("mid_rst_wr_pid", 64'(wr_pid), 64'd0);
        chk("mid_rst_data",   {hi_wr_data, lo_wr_data}, 64'd0);
        run_op(2'd3, 2'd3, 32'd100, 32'd7, 64'h0000_0002_0000_000E);
        repeat (40) tick();

        // Randomised ops against the arithmetic reference.
        for (int i = 0; i < 60; i++) begin
            logic [1:0]  op;
            logic [1:0]  pid;
            logic [31:0] a;
            logic [31:0] b;
            op  = 2'($urandom_range(0, 3));
            pid = 2'($urandom_range(0, 3));
            a   = rnd_word();
            b   = rnd_word();
            run_op(op, pid, a, b, ref_md(op, a, b));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
